sdram_arb: RTL and testbench

- Two-client request arbiter that sits directly upstream of the SDRAM controller and feeds its single-word command port.
- Clients are client 0 (display scan-out reads) and client 1 (rasterizer reads/writes).
- Latches one granted request, presents it to the controller until accepted, tracks the single outstanding read, and routes returned read data to its owner.
- Exactly one transaction is in flight at any time.

---
 rtl/sdram_arb.sv | 186 ++++++++++++++++++
 tb/tb_sdram_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb.sv
// sdram_arb: two-client arbiter feeding the single-word command port of the
// SDRAM controller. Client 0 is display scan-out and client 1 is the
// rasterizer. The arbiter grants one request, holds the command on the
// controller port until the controller accepts it, waits for read data when
// the command is a read, and returns that data to the client that asked for it.
// Only one transaction is in flight at a time.
//
// Optional feature: define SDRAM_ARB_PRIO_EN to give client 0 fixed priority.
// This removes the round-robin pointer. When it is not defined, the arbiter
// uses round-robin.
//
// Ports:
//   clk_i, rst_i          clock and asynchronous active-high reset
//   cN_req_i / cN_we_i    client request valid and write (1) / read (0)
//   cN_addr_i / wdata_i   client word address and write data
//   cN_ready_o            one-cycle pulse when the request is granted
//   cN_rvalid_o / rdata_o one-cycle read-data pulse; the data is held
//                         until the next read for that client
//   mem_enabled_i         controller initialisation is complete
//   mem_data_ready_i      controller accepts a command this cycle
//   mem_addr_o            command address
//   mem_write_o           command write data
//   mem_r_valid_o         read command valid
//   mem_w_valid_o         write command valid
//   mem_r_valid_i         controller read data valid
//   mem_read_i            controller read data
//   timeout_o             sticky flag, set when a read is abandoned
module sdram_arb #(
   parameter int unsigned ADDR_WIDTH     = 24,
   parameter int unsigned BUS_WIDTH      = 16,
   parameter int unsigned RD_MASK_CYCLES = 4,
   parameter int unsigned RD_TIMEOUT     = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  c0_req_i,
   input  logic                  c0_we_i,
   input  logic [ADDR_WIDTH-1:0] c0_addr_i,
   input  logic [BUS_WIDTH-1:0]  c0_wdata_i,
   output logic                  c0_ready_o,
   output logic                  c0_rvalid_o,
   output logic [BUS_WIDTH-1:0]  c0_rdata_o,
   input  logic                  c1_req_i,
   input  logic                  c1_we_i,
   input  logic [ADDR_WIDTH-1:0] c1_addr_i,
   input  logic [BUS_WIDTH-1:0]  c1_wdata_i,
   output logic                  c1_ready_o,
   output logic                  c1_rvalid_o,
   output logic [BUS_WIDTH-1:0]  c1_rdata_o,
   input  logic                  mem_enabled_i,
   input  logic                  mem_data_ready_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_r_valid_o,
   output logic                  mem_w_valid_o,
   output logic [BUS_WIDTH-1:0]  mem_write_o,
   input  logic                  mem_r_valid_i,
   input  logic [BUS_WIDTH-1:0]  mem_read_i,
   output logic                  timeout_o
);

   localparam logic [7:0] LP_MASK = 8'(RD_MASK_CYCLES);
   localparam logic [7:0] LP_TOUT = 8'(RD_TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RD
   } state_t;

   state_t                r_state;
   logic                  r_owner;   // 1 = client 1 owns the transaction
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [BUS_WIDTH-1:0]  r_wdata;
   logic [7:0]            r_cnt;
   logic                  r_c0_ready;
   logic                  r_c1_ready;
   logic                  r_c0_rvalid;
   logic                  r_c1_rvalid;
   logic [BUS_WIDTH-1:0]  r_c0_rdata;
   logic [BUS_WIDTH-1:0]  r_c1_rdata;
   logic                  r_timeout;
`ifndef SDRAM_ARB_PRIO_EN
   logic                  r_rr;      // client that received the last grant
`endif

   logic       w_grant_valid;
   logic       w_grant_c1;
   logic [7:0] w_cnt_next;

   assign w_grant_valid = mem_enabled_i & (c0_req_i | c1_req_i);
`ifdef SDRAM_ARB_PRIO_EN
   assign w_grant_c1    = c1_req_i & ~c0_req_i;
`else
   // When both clients request, grant the client that does not hold the pointer.
   assign w_grant_c1    = c1_req_i & (~c0_req_i | ~r_rr);
`endif
   assign w_cnt_next    = r_cnt + 8'd1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_c0_ready  <= 1'b0;
         r_c1_ready  <= 1'b0;
         r_c0_rvalid <= 1'b0;
         r_c1_rvalid <= 1'b0;
         r_c0_rdata  <= '0;
         r_c1_rdata  <= '0;
         r_timeout   <= 1'b0;
`ifndef SDRAM_ARB_PRIO_EN
         r_rr        <= 1'b0;
`endif
      end else begin
         r_c0_ready  <= 1'b0;
         r_c1_ready  <= 1'b0;
         r_c0_rvalid <= 1'b0;
         r_c1_rvalid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_valid) begin
                  r_owner <= w_grant_c1;
                  r_we    <= w_grant_c1 ? c1_we_i    : c0_we_i;
                  r_addr  <= w_grant_c1 ? c1_addr_i  : c0_addr_i;
                  r_wdata <= w_grant_c1 ? c1_wdata_i : c0_wdata_i;
                  if (w_grant_c1) r_c1_ready <= 1'b1;
                  else            r_c0_ready <= 1'b1;
`ifndef SDRAM_ARB_PRIO_EN
                  r_rr    <= w_grant_c1;
`endif
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // The controller accepts the command on an edge where ready is
               // high. Leaving ISSUE on that edge drops the valids on the
               // next cycle, so the command is accepted only once.
               if (mem_data_ready_i) begin
                  if (r_we) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt   <= '0;
                     r_state <= S_WAIT_RD;
                  end
               end
            end
            S_WAIT_RD: begin
               r_cnt <= w_cnt_next;
               // During the first LP_MASK cycles, mem_r_valid_i may still be
               // high from the previous read, so it is ignored.
               if (mem_r_valid_i && (r_cnt >= LP_MASK)) begin
                  if (r_owner) begin
                     r_c1_rdata  <= mem_read_i;
                     r_c1_rvalid <= 1'b1;
                  end else begin
                     r_c0_rdata  <= mem_read_i;
                     r_c0_rvalid <= 1'b1;
                  end
                  r_state <= S_IDLE;
               end else if (w_cnt_next == LP_TOUT) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign c0_ready_o    = r_c0_ready;
   assign c1_ready_o    = r_c1_ready;
   assign c0_rvalid_o   = r_c0_rvalid;
   assign c1_rvalid_o   = r_c1_rvalid;
   assign c0_rdata_o    = r_c0_rdata;
   assign c1_rdata_o    = r_c1_rdata;
   assign timeout_o     = r_timeout;
   assign mem_addr_o    = r_addr;
   assign mem_write_o   = r_wdata;
   assign mem_r_valid_o = (r_state == S_ISSUE) & ~r_we;
   assign mem_w_valid_o = (r_state == S_ISSUE) &  r_we;

endmodule

// File: tb/tb_sdram_arb.sv
module tb_sdram_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        c0_req, c0_we, c1_req, c1_we;
   logic [23:0] c0_addr, c1_addr;
   logic [15:0] c0_wdata, c1_wdata;
   logic        c0_ready, c0_rvalid, c1_ready, c1_rvalid;
   logic [15:0] c0_rdata, c1_rdata;
   logic        mem_enabled, mem_data_ready;
   logic [23:0] mem_addr;
   logic        mem_r_valid_o, mem_w_valid_o;
   logic [15:0] mem_write;
   logic        mem_r_valid_i;
   logic [15:0] mem_read;
   logic        timeout;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sdram_arb #(
      .ADDR_WIDTH    (24),
      .BUS_WIDTH     (16),
      .RD_MASK_CYCLES(4),
      .RD_TIMEOUT    (64)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .c0_req_i        (c0_req),
      .c0_we_i         (c0_we),
      .c0_addr_i       (c0_addr),
      .c0_wdata_i      (c0_wdata),
      .c0_ready_o      (c0_ready),
      .c0_rvalid_o     (c0_rvalid),
      .c0_rdata_o      (c0_rdata),
      .c1_req_i        (c1_req),
      .c1_we_i         (c1_we),
      .c1_addr_i       (c1_addr),
      .c1_wdata_i      (c1_wdata),
      .c1_ready_o      (c1_ready),
      .c1_rvalid_o     (c1_rvalid),
      .c1_rdata_o      (c1_rdata),
      .mem_enabled_i   (mem_enabled),
      .mem_data_ready_i(mem_data_ready),
      .mem_addr_o      (mem_addr),
      .mem_r_valid_o   (mem_r_valid_o),
      .mem_w_valid_o   (mem_w_valid_o),
      .mem_write_o     (mem_write),
      .mem_r_valid_i   (mem_r_valid_i),
      .mem_read_i      (mem_read),
      .timeout_o       (timeout)
   );

   // Advance one clock edge and settle. Inputs are driven and outputs are sampled here.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
      c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
      mem_enabled = 1; mem_data_ready = 0; mem_r_valid_i = 0; mem_read = '0;
      tick(); tick();
      n_total++;
      if ({c0_ready, c1_ready, c0_rvalid, c1_rvalid, mem_r_valid_o, mem_w_valid_o, timeout} !== 7'b0)
         $display("FAIL reset_flags got=%b exp=0", {c0_ready, c1_ready, c0_rvalid, c1_rvalid, mem_r_valid_o, mem_w_valid_o, timeout});
      else n_pass++;
      n_total++;
      if ({mem_addr, mem_write, c0_rdata, c1_rdata} !== 72'h0)
         $display("FAIL reset_buses got=%h exp=0", {mem_addr, mem_write, c0_rdata, c1_rdata});
      else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_read;
      c0_req = 1; c0_we = 0; c0_addr = 24'h000123;
      tick();
      c0_req = 0;
      n_total++;
      if (c0_ready !== 1'b1 || c1_ready !== 1'b0) $display("FAIL rd_ready got=%b%b exp=10", c0_ready, c1_ready);
      else n_pass++;
      n_total++;
      if (mem_r_valid_o !== 1'b1 || mem_w_valid_o !== 1'b0 || mem_addr !== 24'h000123)
         $display("FAIL rd_issue got=%b%b %h exp=10 000123", mem_r_valid_o, mem_w_valid_o, mem_addr);
      else n_pass++;
      tick();
      n_total++;
      if (c0_ready !== 1'b0 || mem_r_valid_o !== 1'b1) $display("FAIL rd_hold got=%b%b exp=01", c0_ready, mem_r_valid_o);
      else n_pass++;
      mem_data_ready = 1;
      tick();
      mem_data_ready = 0;
      n_total++;
      if (mem_r_valid_o !== 1'b0) $display("FAIL rd_valid_drop got=%b exp=0", mem_r_valid_o);
      else n_pass++;
      // Mask lifts when the counter reaches 4. The data returns 2 cycles after that.
      repeat (6) tick();
      mem_r_valid_i = 1; mem_read = 16'hBEEF;
      tick();
      mem_r_valid_i = 0;
      n_total++;
      if (c0_rvalid !== 1'b1 || c1_rvalid !== 1'b0 || c0_rdata !== 16'hBEEF)
         $display("FAIL rd_return got=%b%b %h exp=10 beef", c0_rvalid, c1_rvalid, c0_rdata);
      else n_pass++;
      tick();
      n_total++;
      if (c0_rvalid !== 1'b0 || c0_rdata !== 16'hBEEF)
         $display("FAIL rd_hold_data got=%b %h exp=0 beef", c0_rvalid, c0_rdata);
      else n_pass++;
   endtask

   task automatic test_write;
      int high_cnt = 0;
      logic bad = 0;
      c1_req = 1; c1_we = 1; c1_addr = 24'h0000FF; c1_wdata = 16'h1234;
      tick();
      c1_req = 0;
      n_total++;
      if (c1_ready !== 1'b1 || c0_ready !== 1'b0) $display("FAIL wr_ready got=%b%b exp=01", c0_ready, c1_ready);
      else n_pass++;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (mem_w_valid_o) begin
            high_cnt++;
            if (mem_write !== 16'h1234 || mem_addr !== 24'h0000FF || mem_r_valid_o) bad = 1;
         end
         if (c0_rvalid || c1_rvalid) bad = 1;
         mem_data_ready = (cyc == 3);
         tick();
      end
      mem_data_ready = 0;
      n_total++;
      if (high_cnt != 4) $display("FAIL wr_valid_cycles got=%0d exp=4", high_cnt);
      else n_pass++;
      n_total++;
      if (bad !== 1'b0) $display("FAIL wr_bus_content got=%b exp=0", bad);
      else n_pass++;
   endtask

   task automatic test_contention;
      logic [3:0] got = '0;
      logic [3:0] exp;
      int ng = 0;
      logic addr_bad = 0;
`ifdef SDRAM_ARB_PRIO_EN
      exp = 4'b0000;
`else
      exp = 4'b1010;   // grant k is at bit k: c0,c1,c0,c1
`endif
      c0_req = 1; c0_we = 1; c0_addr = 24'h00000A; c0_wdata = 16'h0A0A;
      c1_req = 1; c1_we = 1; c1_addr = 24'h00000B; c1_wdata = 16'h0B0B;
      mem_data_ready = 1;
      for (int cyc = 0; cyc < 20 && ng < 4; cyc++) begin
         tick();
         if (c0_ready || c1_ready) begin
            got[ng] = c1_ready;
            if (mem_addr !== (c1_ready ? 24'h00000B : 24'h00000A)) addr_bad = 1;
            ng++;
         end
      end
      c0_req = 0; c1_req = 0;
      tick();
      mem_data_ready = 0;
      n_total++;
      if (ng != 4 || got !== exp) $display("FAIL contention_order got=%0d/%b exp=4/%b", ng, got, exp);
      else n_pass++;
      n_total++;
      if (addr_bad !== 1'b0) $display("FAIL contention_addr got=%b exp=0", addr_bad);
      else n_pass++;
   endtask

   task automatic test_enable;
      mem_enabled = 0;
      c0_req = 1; c0_we = 1; c0_addr = 24'h000055; c0_wdata = 16'h5555;
      tick(); tick(); tick();
      n_total++;
      if (c0_ready !== 1'b0 || mem_w_valid_o !== 1'b0) $display("FAIL en_block got=%b%b exp=00", c0_ready, mem_w_valid_o);
      else n_pass++;
      mem_enabled = 1;
      tick();
      c0_req = 0;
      n_total++;
      if (c0_ready !== 1'b1) $display("FAIL en_grant got=%b exp=1", c0_ready);
      else n_pass++;
      mem_enabled = 0;
      tick(); tick();
      n_total++;
      if (mem_w_valid_o !== 1'b1 || mem_addr !== 24'h000055) $display("FAIL en_hold got=%b %h exp=1 000055", mem_w_valid_o, mem_addr);
      else n_pass++;
      mem_enabled = 1; mem_data_ready = 1;
      tick();
      mem_data_ready = 0;
   endtask

   task automatic test_stale_guard;
      int k = 0;
      c0_req = 1; c0_we = 0; c0_addr = 24'h000777;
      tick();
      c0_req = 0;
      mem_data_ready = 1; mem_r_valid_i = 1; mem_read = 16'hAAAA;
      tick();
      mem_data_ready = 0;
      for (int i = 1; i <= 20 && k == 0; i++) begin
         tick();
         if (c0_rvalid) k = i;
      end
      mem_r_valid_i = 0;
      n_total++;
      if (k != 5) $display("FAIL stale_capture_cycle got=%0d exp=5", k);
      else n_pass++;
      n_total++;
      if (c0_rdata !== 16'hAAAA) $display("FAIL stale_data got=%h exp=aaaa", c0_rdata);
      else n_pass++;
      tick();
   endtask

   task automatic test_timeout;
      int k = 0;
      logic saw_rv = 0;
      c1_req = 1; c1_we = 0; c1_addr = 24'h000900;
      tick();
      c1_req = 0;
      mem_data_ready = 1;
      tick();
      mem_data_ready = 0;
      for (int i = 1; i <= 100 && k == 0; i++) begin
         tick();
         if (c0_rvalid || c1_rvalid) saw_rv = 1;
         if (timeout) k = i;
      end
      n_total++;
      if (k != 64 || saw_rv !== 1'b0) $display("FAIL timeout_cycle got=%0d rv=%b exp=64 rv=0", k, saw_rv);
      else n_pass++;
      c0_req = 1; c0_we = 1; c0_addr = 24'h000042; c0_wdata = 16'h4242;
      tick();
      c0_req = 0;
      n_total++;
      if (c0_ready !== 1'b1 || mem_w_valid_o !== 1'b1 || timeout !== 1'b1)
         $display("FAIL timeout_next_grant got=%b%b%b exp=111", c0_ready, mem_w_valid_o, timeout);
      else n_pass++;
      mem_data_ready = 1;
      tick();
      mem_data_ready = 0;
   endtask

   task automatic test_reset_in_wait;
      logic saw_rv = 0;
      c0_req = 1; c0_we = 0; c0_addr = 24'h000333;
      tick();
      c0_req = 0;
      mem_data_ready = 1;
      tick();
      mem_data_ready = 0;
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      n_total++;
      if ({c0_ready, c1_ready, c0_rvalid, c1_rvalid, mem_r_valid_o, mem_w_valid_o, timeout} !== 7'b0 ||
          {mem_addr, mem_write, c0_rdata, c1_rdata} !== 72'h0)
         $display("FAIL async_reset got=%b %h exp=0 0",
                  {c0_ready, c1_ready, c0_rvalid, c1_rvalid, mem_r_valid_o, mem_w_valid_o, timeout},
                  {mem_addr, mem_write, c0_rdata, c1_rdata});
      else n_pass++;
      #2 rst = 1'b0;
      mem_r_valid_i = 1; mem_read = 16'h5A5A;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (c0_rvalid || c1_rvalid) saw_rv = 1;
      end
      mem_r_valid_i = 0;
      n_total++;
      if (saw_rv !== 1'b0 || c0_rdata !== 16'h0) $display("FAIL reset_drop_read got=%b %h exp=0 0000", saw_rv, c0_rdata);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_contention();
      test_enable();
      test_stale_guard();
      test_timeout();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
